// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit; runs one req/gnt/rvalid bus access per
// load/store, formats load data for writeback and stalls the pipeline until it completes.
module lsu_mem_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      func3_m,
    input  logic [DW-1:0]   addr_m,
    input  logic [DW-1:0]   wdata_m,
    input  logic            hold_i,
    output logic            stall_o,
    output logic [DW-1:0]   load_data_o,
    output logic            load_valid_o,
    output logic            err_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [DW-1:0]   bus_addr_o,
    output logic [DW/8-1:0] bus_be_o,
    output logic [DW-1:0]   bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [DW-1:0]   bus_rdata_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic [2:0]      r_func3;
    logic            r_we;
    logic [DW/8-1:0] r_be;

    logic            w_acc;
    logic            w_bad;
    logic            w_start;
    logic            w_tmo;
    logic [4:0]      w_sh;
    logic [DW/8-1:0] w_be;
    logic [DW-1:0]   w_wdata;
    logic [DW-1:0]   w_lane;
    logic [DW-1:0]   w_fmt;

    assign w_acc = mem_read_m | mem_write_m;
    // Stores have no unsigned variants, so any func3[2] store is illegal.
    assign w_bad = (func3_m[1:0] == 2'b11) | (func3_m == 3'b110) | (!mem_read_m & func3_m[2])
                 | (func3_m[1:0] == 2'b01 & addr_m[0]) | (func3_m[1:0] == 2'b10 & addr_m[1:0] != 2'b00);
    assign w_start = (r_state == S_IDLE) & w_acc & !w_bad;
    assign w_sh = {addr_m[1:0], 3'b000};
    assign w_be = func3_m[1:0] == 2'b00 ? 4'b0001 << addr_m[1:0]
                : func3_m[1:0] == 2'b01 ? 4'b0011 << addr_m[1:0] : 4'b1111;
    assign w_wdata = func3_m[1:0] == 2'b00 ? {24'b0, wdata_m[7:0]} << w_sh
                   : func3_m[1:0] == 2'b01 ? {16'b0, wdata_m[15:0]} << w_sh : wdata_m;
    assign w_lane = bus_rdata_i >> {r_addr[1:0], 3'b000};
    assign w_fmt = r_func3 == 3'b000 ? {{24{w_lane[7]}}, w_lane[7:0]}
                 : r_func3 == 3'b001 ? {{16{w_lane[15]}}, w_lane[15:0]}
                 : r_func3 == 3'b100 ? {24'b0, w_lane[7:0]}
                 : r_func3 == 3'b101 ? {16'b0, w_lane[15:0]} : w_lane;
    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1))
                 & ((r_state == S_REQ & !bus_gnt_i) | (r_state == S_WAIT & !bus_rvalid_i));

    // Input-dependent outputs are gated so everything reads 0 while reset is held.
    assign stall_o      = rst_ni & (w_start | r_state == S_REQ | r_state == S_WAIT);
    assign err_o        = rst_ni & (((r_state == S_IDLE) & w_acc & w_bad) | w_tmo);
    assign bus_req_o    = r_state == S_REQ;
    assign load_valid_o = (r_state == S_DONE) & !r_we;
    assign load_data_o  = r_rdata;
    assign bus_we_o     = r_we;
    assign bus_addr_o   = {r_addr[DW-1:2], 2'b00};
    assign bus_be_o     = r_be;
    assign bus_wdata_o  = r_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_func3 <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_addr  <= addr_m;
                        r_func3 <= func3_m;
                        r_we    <= !mem_read_m;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_rdata <= '0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= r_we ? S_DONE : S_WAIT;
                    end else if (w_tmo) begin
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid_i) begin
                        r_cnt   <= '0;
                        r_rdata <= w_fmt;
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (!hold_i) r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
